// File: rtl/sae_pkg.sv
// Shared types, constants and character-class helpers for the streaming
// Vigenere-style cipher.
package sae_pkg;

  typedef enum logic [1:0] {
    NO_KEY = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2
  } sae_state_e;

  localparam int ALPHA_LEN = 26;

  localparam logic [7:0] CH_UA = 8'h41;  // 'A'
  localparam logic [7:0] CH_UZ = 8'h5A;  // 'Z'
  localparam logic [7:0] CH_LA = 8'h61;  // 'a'
  localparam logic [7:0] CH_LZ = 8'h7A;  // 'z'

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= CH_UA) && (c <= CH_UZ);
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= CH_LA) && (c <= CH_LZ);
  endfunction

  function automatic logic is_letter(input logic [7:0] c);
    return is_upper(c) || is_lower(c);
  endfunction

endpackage

// File: rtl/sae_stream_if.sv
// Key, input and output stream signals of the cipher, grouped for one port.
interface sae_stream_if;

  logic       key_valid;
  logic [7:0] key_char;
  logic       key_last;
  logic       key_ready;

  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_mode;
  logic       in_last;

  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  logic       err_invalid_ptxt_char;
  logic       err_invalid_ctxt_char;
  logic       err_invalid_seckey;

  modport slave (
    input  key_valid, key_char, key_last,
    output key_ready,
    input  in_valid, in_data, in_mode, in_last,
    output in_ready,
    output out_valid, out_data, out_last,
    input  out_ready,
    output err_invalid_ptxt_char, err_invalid_ctxt_char, err_invalid_seckey
  );

  modport master (
    output key_valid, key_char, key_last,
    input  key_ready,
    output in_valid, in_data, in_mode, in_last,
    input  in_ready,
    input  out_valid, out_data, out_last,
    output out_ready,
    input  err_invalid_ptxt_char, err_invalid_ctxt_char, err_invalid_seckey
  );

endinterface

// File: rtl/sae_shift.sv
// Combinational single-character shifter: encrypts or decrypts one letter by
// one key letter, preserving case; non-letters give 8'h00 and the invalid flag.
module sae_shift
  import sae_pkg::*;
(
  input  logic [7:0] data_char,
  input  logic [7:0] key_char,
  input  logic       mode,
  output logic [7:0] result,
  output logic       invalid
);

  logic [7:0] base;
  logic [4:0] p;
  logic [4:0] k;
  logic [5:0] s;

  always_comb begin
    base    = is_lower(data_char) ? CH_LA : CH_UA;
    invalid = !is_letter(data_char);
    p       = 5'(data_char - base);
    k       = 5'(key_char - CH_UA);
    s       = '0;
    if (!mode) begin
      s = {1'b0, p} + {1'b0, k};
      if (s >= 6'(ALPHA_LEN)) begin
        s = s - 6'(ALPHA_LEN);
      end
    end else begin
      if (p >= k) begin
        s = {1'b0, p} - {1'b0, k};
      end else begin
        s = {1'b0, p} + 6'(ALPHA_LEN) - {1'b0, k};
      end
    end
    result = invalid ? 8'h00 : base + {2'b00, s};
  end

endmodule

// File: rtl/sae_stream.sv
// Streaming multi-character shift cipher: key loader FSM, key register file,
// key index counter and a single output register with valid/ready handshake.
module sae_stream
  import sae_pkg::*;
#(
  parameter int KEY_LEN = 8,
  parameter int IDX_W   = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1
) (
  input  logic         clk,
  input  logic         rst,
  sae_stream_if.slave  bus
);

  localparam logic [IDX_W-1:0] SLOT_MAX = IDX_W'(KEY_LEN - 1);

  sae_state_e       state_q, state_d;
  logic [7:0]       key_q [KEY_LEN];
  logic [7:0]       key_d [KEY_LEN];
  logic [IDX_W-1:0] key_max_q, key_max_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] load_idx_q, load_idx_d;
  logic             load_full_q, load_full_d;
  logic             discard_q, discard_d;
  logic             seckey_err_q, seckey_err_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             err_ptxt_q, err_ptxt_d;
  logic             err_ctxt_q, err_ctxt_d;

  logic             in_ready;
  logic             in_acc;
  logic             key_acc;
  logic [7:0]       shift_res;
  logic             shift_inv;
  logic             key_take;
  logic             key_ovf;
  logic [IDX_W-1:0] key_slot;

  sae_shift u_shift (
    .data_char (bus.in_data),
    .key_char  (key_q[idx_q]),
    .mode      (bus.in_mode),
    .result    (shift_res),
    .invalid   (shift_inv)
  );

  assign in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready);
  assign in_acc   = bus.in_valid && in_ready;
  assign key_acc  = bus.key_valid;

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    key_max_d    = key_max_q;
    idx_d        = idx_q;
    load_idx_d   = load_idx_q;
    load_full_d  = load_full_q;
    discard_d    = discard_q;
    seckey_err_d = seckey_err_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    err_ptxt_d   = err_ptxt_q;
    err_ctxt_d   = err_ctxt_q;
    key_take     = 1'b0;
    key_ovf      = 1'b0;
    key_slot     = '0;

    if (in_acc) begin
      out_valid_d = 1'b1;
      out_data_d  = shift_res;
      out_last_d  = bus.in_last;
      err_ptxt_d  = shift_inv && !bus.in_mode;
      err_ctxt_d  = shift_inv && bus.in_mode;
      if (bus.in_last) begin
        idx_d = '0;
      end else if (!shift_inv) begin
        idx_d = (idx_q == key_max_q) ? '0 : idx_q + 1'b1;
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
      err_ptxt_d  = 1'b0;
      err_ctxt_d  = 1'b0;
    end

    // Key handling runs after the data path so a key beat in RUN overrides
    // the index only after the concurrent data beat has used the old key.
    if (key_acc) begin
      case (state_q)
        NO_KEY: begin
          if (discard_q) begin
            if (bus.key_last) discard_d = 1'b0;
          end else begin
            key_take     = 1'b1;
            seckey_err_d = 1'b0;
          end
        end
        LOAD: begin
          key_take = 1'b1;
          key_slot = load_idx_q;
          key_ovf  = load_full_q;
        end
        RUN: begin
          key_take     = 1'b1;
          seckey_err_d = 1'b0;
        end
        default: ;
      endcase
    end

    if (key_take) begin
      idx_d = '0;
      if (key_ovf || !is_upper(bus.key_char)) begin
        seckey_err_d = 1'b1;
        state_d      = NO_KEY;
        discard_d    = !bus.key_last;
        load_full_d  = 1'b0;
        load_idx_d   = '0;
      end else begin
        key_d[key_slot] = bus.key_char;
        load_full_d     = (key_slot == SLOT_MAX);
        load_idx_d      = key_slot + 1'b1;
        if (bus.key_last) begin
          state_d   = RUN;
          key_max_d = key_slot;
        end else begin
          state_d = LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NO_KEY;
      for (int i = 0; i < KEY_LEN; i++) key_q[i] <= '0;
      key_max_q    <= '0;
      idx_q        <= '0;
      load_idx_q   <= '0;
      load_full_q  <= 1'b0;
      discard_q    <= 1'b0;
      seckey_err_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= 8'h00;
      out_last_q   <= 1'b0;
      err_ptxt_q   <= 1'b0;
      err_ctxt_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      key_max_q    <= key_max_d;
      idx_q        <= idx_d;
      load_idx_q   <= load_idx_d;
      load_full_q  <= load_full_d;
      discard_q    <= discard_d;
      seckey_err_q <= seckey_err_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      err_ptxt_q   <= err_ptxt_d;
      err_ctxt_q   <= err_ctxt_d;
    end
  end

  assign bus.key_ready             = 1'b1;
  assign bus.in_ready              = in_ready;
  assign bus.out_valid             = out_valid_q;
  assign bus.out_data              = out_data_q;
  assign bus.out_last              = out_last_q;
  assign bus.err_invalid_ptxt_char = err_ptxt_q;
  assign bus.err_invalid_ctxt_char = err_ctxt_q;
  assign bus.err_invalid_seckey    = seckey_err_q;

endmodule

// File: tb/tb_sae_stream.sv
// Bench for sae_stream: directed cases plus randomized keys/messages checked
// against a modular-arithmetic reference model with an output scoreboard.
module tb_sae_stream;

  localparam int KL = 8;

  typedef struct {
    logic [7:0] d;
    logic       last;
    logic       ep;
    logic       ec;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sae_stream_if bus();

  sae_stream #(.KEY_LEN(KL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  string      mdl_key = "";
  int         mdl_pos = 0;
  beat_t      exp_q[$];
  logic [7:0] got_q[$];
  int         acc_cyc_q[$];
  int         cyc = 0;
  bit         rdy_force = 1'b1;

  function automatic bit is_alpha(input logic [7:0] c);
    return (c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122);
  endfunction

  function automatic beat_t ref_beat(input logic [7:0] c, input bit dec, input bit last,
                                     input string key, input int pos);
    beat_t e;
    int base, p, k, r;
    e.last = last;
    if (is_alpha(c)) begin
      base = (c >= 8'd97) ? 97 : 65;
      p    = int'(c) - base;
      k    = (key.len() == 0) ? 0 : int'(key[pos % key.len()]) - 65;
      r    = dec ? (p - k + 26) % 26 : (p + k) % 26;
      e.d  = 8'(base + r);
      e.ep = 1'b0;
      e.ec = 1'b0;
    end else begin
      e.d  = 8'h00;
      e.ep = !dec;
      e.ec = dec;
    end
    return e;
  endfunction

  // Monitor / scoreboard, sampling on the falling edge
  bit         hold_pending = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;
  bit         acc_prev = 1'b0;
  beat_t      mon_e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      mdl_pos      = 0;
      hold_pending = 1'b0;
      acc_prev     = 1'b0;
    end else begin
      if (acc_prev) chk("latency_out_valid", bus.out_valid, 1);
      if (hold_pending) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_data", bus.out_data, hold_data);
        chk("hold_last", bus.out_last, hold_last);
      end
      if (bus.out_valid && !bus.out_ready) chk("bp_in_ready", bus.in_ready, 0);
      hold_pending = bus.out_valid && !bus.out_ready;
      hold_data    = bus.out_data;
      hold_last    = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", bus.out_data, mon_e.d);
          chk("out_last", bus.out_last, mon_e.last);
          chk("err_ptxt", bus.err_invalid_ptxt_char, mon_e.ep);
          chk("err_ctxt", bus.err_invalid_ctxt_char, mon_e.ec);
        end
        got_q.push_back(bus.out_data);
      end
      acc_prev = bus.in_valid && bus.in_ready;
      if (acc_prev) begin
        exp_q.push_back(ref_beat(bus.in_data, bus.in_mode, bus.in_last, mdl_key, mdl_pos));
        acc_cyc_q.push_back(cyc);
        if (is_alpha(bus.in_data)) mdl_pos++;
        if (bus.in_last) mdl_pos = 0;
      end
    end
  end

  bit rdy_rand = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!rdy_force) bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && t < 100) begin
      tick();
      t++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic send_key(input string s);
    bit ok;
    bit acc;
    int t;
    drain();
    ok = (s.len() >= 1) && (s.len() <= KL);
    for (int i = 0; i < s.len(); i++) begin
      if (!(s[i] >= 8'd65 && s[i] <= 8'd90)) ok = 1'b0;
    end
    for (int i = 0; i < s.len(); i++) begin
      bus.key_valid = 1'b1;
      bus.key_char  = s[i];
      bus.key_last  = (i == s.len() - 1);
      t = 0;
      do begin
        @(negedge clk);
        acc = bus.key_ready;
        tick();
        t++;
      end while (!acc && t < 20);
      if (!acc) chk("key_timeout", 0, 1);
    end
    bus.key_valid = 1'b0;
    bus.key_last  = 1'b0;
    if (ok) begin
      mdl_key = s;
      mdl_pos = 0;
    end
    chk("seckey_err", bus.err_invalid_seckey, !ok);
    chk("in_ready_after_key", bus.in_ready, ok);
    $display("key \"%s\" loaded: valid=%0d err_invalid_seckey=%0d", s, ok, bus.err_invalid_seckey);
  endtask

  task automatic send_msg(input string s, input bit dec);
    bit acc;
    int t;
    for (int i = 0; i < s.len(); i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = s[i];
      bus.in_mode  = dec;
      bus.in_last  = (i == s.len() - 1);
      t = 0;
      do begin
        @(negedge clk);
        acc = bus.in_ready;
        tick();
        t++;
      end while (!acc && t < 50);
      if (!acc) chk("data_timeout", 0, 1);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    $display("msg \"%s\" mode=%0d sent", s, dec);
  endtask

  task automatic expect_stream(input string tag, input string s);
    chk({tag, "_len"}, got_q.size(), s.len());
    for (int i = 0; i < s.len() && i < got_q.size(); i++) chk(tag, got_q[i], s[i]);
    got_q.delete();
  endtask

  function automatic logic [7:0] rand_char();
    logic [7:0] tbl [6];
    int r;
    tbl = '{8'h30, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h20};
    r = $urandom_range(0, 9);
    if (r < 4) return 8'(65 + $urandom_range(0, 25));
    if (r < 8) return 8'(97 + $urandom_range(0, 25));
    return tbl[$urandom_range(0, 5)];
  endfunction

  function automatic string rand_key(input bit allow_bad);
    string s = "";
    int n = allow_bad ? $urandom_range(1, KL + 1) : $urandom_range(1, KL);
    for (int i = 0; i < n; i++) begin
      if (allow_bad && $urandom_range(0, 9) == 0)
        s = $sformatf("%s%c", s, ($urandom_range(0, 1) != 0) ? 8'h5B : 8'h62);
      else
        s = $sformatf("%s%c", s, 8'(65 + $urandom_range(0, 25)));
    end
    return s;
  endfunction

  initial begin
    string k;
    string m;
    bus.key_valid = 1'b0;
    bus.key_char  = 8'h00;
    bus.key_last  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.in_mode   = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_key_ready", bus.key_ready, 1);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_err_ptxt", bus.err_invalid_ptxt_char, 0);
    chk("rst_err_ctxt", bus.err_invalid_ctxt_char, 0);
    chk("rst_err_seckey", bus.err_invalid_seckey, 0);
    rst = 1'b0;
    tick();

    // Basic encrypt / decrypt with full throughput
    send_key("KEY");
    got_q.delete();
    acc_cyc_q.delete();
    send_msg("HELLO", 1'b0);
    drain();
    expect_stream("enc_HELLO", "RIJVS");
    chk("throughput_beats", acc_cyc_q.size(), 5);
    if (acc_cyc_q.size() == 5) chk("throughput_span", acc_cyc_q[4] - acc_cyc_q[0], 4);
    send_msg("RIJVS", 1'b1);
    drain();
    expect_stream("dec_RIJVS", "HELLO");
    send_msg("hello", 1'b0);
    drain();
    expect_stream("enc_hello", "rijvs");

    // Invalid data characters do not advance the key index
    send_msg("H1E", 1'b0);
    drain();
    chk("inv_len", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("inv_0", got_q[0], 8'h52);
      chk("inv_1", got_q[1], 8'h00);
      chk("inv_2", got_q[2], 8'h49);
    end
    got_q.delete();
    send_msg("#", 1'b1);
    drain();
    chk("inv_dec_len", got_q.size(), 1);
    if (got_q.size() == 1) chk("inv_dec", got_q[0], 8'h00);
    got_q.delete();

    // Key errors: overflow and lowercase, then recovery
    send_key("ABCDEFGHI");
    send_key("b");
    send_key("B");
    send_msg("A", 1'b0);
    drain();
    expect_stream("key_B", "B");

    // Three cycles of backpressure in the middle of a message
    send_key("KEY");
    got_q.delete();
    fork
      send_msg("HELLO", 1'b0);
      begin
        tick();
        tick();
        bus.out_ready = 1'b0;
        repeat (3) tick();
        bus.out_ready = 1'b1;
      end
    join
    drain();
    expect_stream("bp_HELLO", "RIJVS");

    // Randomized keys and messages under random backpressure
    rdy_force = 1'b0;
    rdy_rand  = 1'b1;
    for (int it = 0; it < 25; it++) begin
      k = rand_key(1'b1);
      send_key(k);
      if (bus.err_invalid_seckey) send_key(rand_key(1'b0));
      for (int j = 0; j < 2; j++) begin
        m = "";
        for (int c = 0; c < $urandom_range(1, 10); c++) m = $sformatf("%s%c", m, rand_char());
        send_msg(m, 1'($urandom_range(0, 1)));
      end
      drain();
    end
    got_q.delete();

    // Reset in the middle of a message
    rdy_force = 1'b1;
    bus.out_ready = 1'b1;
    send_key("KEY");
    send_msg("HE", 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h4C;
    bus.in_mode  = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_out_data", bus.out_data, 0);
    chk("midrst_out_last", bus.out_last, 0);
    chk("midrst_in_ready", bus.in_ready, 0);
    chk("midrst_key_ready", bus.key_ready, 1);
    chk("midrst_err_ptxt", bus.err_invalid_ptxt_char, 0);
    chk("midrst_err_seckey", bus.err_invalid_seckey, 0);
    rst = 1'b0;
    tick();
    tick();
    chk("midrst_wait_in_ready", bus.in_ready, 0);
    chk("midrst_wait_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    got_q.delete();
    send_key("KEY");
    send_msg("HELLO", 1'b0);
    drain();
    expect_stream("post_rst_HELLO", "RIJVS");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
